// File: rtl/aesl_deadlock_pkg.sv
// Shared definitions for the cosim deadlock infrastructure: report FSM
// states and width helpers used by the stall detector and the monitors.
package aesl_deadlock_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rpt_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Width of a counter that must hold 0..thresh inclusive.
    function automatic int cnt_w(input int thresh);
        return clog2(thresh + 1);
    endfunction

    // Width of a channel index, never narrower than one bit.
    function automatic int idx_w(input int num_chan);
        return (num_chan < 2) ? 1 : clog2(num_chan);
    endfunction

endpackage

// File: rtl/aesl_axis_stall_counter.sv
// Per-channel stall counter: counts consecutive wait cycles, raises block
// once the threshold is reached and flags the 0->1 edge of block.
module aesl_axis_stall_counter
    import aesl_deadlock_pkg::*;
#(
    parameter int STALL_THRESH = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic waiting,
    output logic block,
    output logic rise
);

    localparam int CNT_W = cnt_w(STALL_THRESH);

    logic [CNT_W-1:0] cnt;
    logic             block_prev;

    // Consecutive-wait counter, saturating at the threshold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!enable || !waiting) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(STALL_THRESH)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Previous block value so each rise is reported exactly once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            block_prev <= 1'b0;
        end else begin
            block_prev <= block;
        end
    end

    assign block = (cnt == CNT_W'(STALL_THRESH));
    assign rise  = block & ~block_prev;

endmodule

// File: rtl/aesl_axis_block_detector.sv
// Per-channel AXI-Stream stall detector with a first-event report slot.
// Channel flags feed the dataflow deadlock monitors; the report slot hands
// the first stall (channel + timestamp) to the testbench reporter.
module aesl_axis_block_detector
    import aesl_deadlock_pkg::*;
#(
    parameter int                  NUM_CHAN     = 2,
    parameter logic [NUM_CHAN-1:0] DIR_MASK     = '0,
    parameter int                  STALL_THRESH = 16,
    parameter int                  TS_W         = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [NUM_CHAN-1:0]           axis_tvalid,
    input  logic [NUM_CHAN-1:0]           axis_tready,
    output logic [NUM_CHAN-1:0]           axis_block_sigs,
    output logic                          any_block,
    output logic                          report_valid,
    input  logic                          report_ready,
    output logic [idx_w(NUM_CHAN)-1:0]    report_idx,
    output logic [TS_W-1:0]               report_ts,
    output logic                          report_overflow
);

    localparam int IDX_W = idx_w(NUM_CHAN);

    logic [NUM_CHAN-1:0] waiting;
    logic [NUM_CHAN-1:0] rise;
    logic [TS_W-1:0]     timestamp;

    rpt_state_t          state, state_nxt;
    logic [IDX_W-1:0]    idx_q, idx_nxt;
    logic [TS_W-1:0]     ts_q, ts_nxt;
    logic                ovf_q, ovf_nxt;

    logic                rise_any;
    logic                rise_multi;
    logic [IDX_W-1:0]    rise_idx;

    // Direction decides which side is the one left waiting; a transfer never waits.
    assign waiting = (DIR_MASK & axis_tready & ~axis_tvalid) |
                     (~DIR_MASK & axis_tvalid & ~axis_tready);

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        aesl_axis_stall_counter #(
            .STALL_THRESH (STALL_THRESH)
        ) u_cnt (
            .clock   (clock),
            .reset   (reset),
            .enable  (enable),
            .waiting (waiting[i]),
            .block   (axis_block_sigs[i]),
            .rise    (rise[i])
        );
    end

    assign any_block = |axis_block_sigs;

    // Lowest-index rising channel, plus whether more than one rose at once.
    always_comb begin
        rise_any   = 1'b0;
        rise_multi = 1'b0;
        rise_idx   = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (rise[i]) begin
                if (rise_any) begin
                    rise_multi = 1'b1;
                end else begin
                    rise_idx = IDX_W'(i);
                    rise_any = 1'b1;
                end
            end
        end
    end

    // Free-running cycle timestamp, restarted by clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timestamp <= '0;
        end else if (clear) begin
            timestamp <= '0;
        end else begin
            timestamp <= timestamp + TS_W'(1);
        end
    end

    // Report FSM next state: capture when the slot is free (or being freed),
    // otherwise only note that a rise was lost.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        ts_nxt    = ts_q;
        ovf_nxt   = ovf_q;
        if (clear) begin
            state_nxt = IDLE;
            ovf_nxt   = 1'b0;
        end else if (state == HOLD && !report_ready) begin
            if (rise_any) begin
                ovf_nxt = 1'b1;
            end
        end else if (rise_any) begin
            state_nxt = HOLD;
            idx_nxt   = rise_idx;
            ts_nxt    = timestamp;
            if (rise_multi) begin
                ovf_nxt = 1'b1;
            end
        end else begin
            state_nxt = IDLE;
        end
    end

    // Report FSM state and captured event registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx_q <= '0;
            ts_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            idx_q <= idx_nxt;
            ts_q  <= ts_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    assign report_valid    = (state == HOLD);
    assign report_idx      = idx_q;
    assign report_ts       = ts_q;
    assign report_overflow = ovf_q;

endmodule

// File: tb/tb_aesl_axis_block_detector.sv
// Bench for aesl_axis_block_detector: directed scenarios followed by a
// randomized phase, all checked against a run-length based reference model.
module tb_aesl_axis_block_detector;

    localparam int         NC   = 4;
    localparam logic [3:0] DIRM = 4'b0101;
    localparam int         TH   = 4;
    localparam int         TSW  = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            enable;
    logic            clear;
    logic [NC-1:0]   tv;
    logic [NC-1:0]   tr;
    logic [NC-1:0]   axis_block_sigs;
    logic            any_block;
    logic            report_valid;
    logic            report_ready;
    logic [1:0]      report_idx;
    logic [TSW-1:0]  report_ts;
    logic            report_overflow;

    aesl_axis_block_detector #(
        .NUM_CHAN     (NC),
        .DIR_MASK     (DIRM),
        .STALL_THRESH (TH),
        .TS_W         (TSW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .clear           (clear),
        .axis_tvalid     (tv),
        .axis_tready     (tr),
        .axis_block_sigs (axis_block_sigs),
        .any_block       (any_block),
        .report_valid    (report_valid),
        .report_ready    (report_ready),
        .report_idx      (report_idx),
        .report_ts       (report_ts),
        .report_overflow (report_overflow)
    );

    always #5 clock = ~clock;

    // Reference model state: consecutive wait run length per channel.
    int              run    [NC];
    bit              prevb  [NC];
    bit              m_pend;
    bit              m_ovf;
    int              m_idx;
    logic [TSW-1:0]  m_rts;
    logic [TSW-1:0]  m_tstamp;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            run[i]   = 0;
            prevb[i] = 1'b0;
        end
        m_pend   = 1'b0;
        m_ovf    = 1'b0;
        m_idx    = 0;
        m_rts    = '0;
        m_tstamp = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int nr;
        int lo;
        bit w;
        nr = 0;
        lo = 0;
        for (int i = 0; i < NC; i++) begin
            if (run[i] >= TH && !prevb[i]) begin
                if (nr == 0) lo = i;
                nr++;
            end
        end
        for (int i = 0; i < NC; i++) begin
            w = DIRM[i] ? (tr[i] & ~tv[i]) : (tv[i] & ~tr[i]);
            prevb[i] = (run[i] >= TH);
            if (enable && w) run[i] = (run[i] >= TH) ? TH : run[i] + 1;
            else             run[i] = 0;
        end
        if (clear) begin
            m_pend = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_pend && !report_ready) begin
            if (nr > 0) m_ovf = 1'b1;
        end else if (nr > 0) begin
            m_pend = 1'b1;
            m_idx  = lo;
            m_rts  = m_tstamp;
            if (nr > 1) m_ovf = 1'b1;
        end else begin
            m_pend = 1'b0;
        end
        m_tstamp = clear ? '0 : m_tstamp + 1;
    endtask

    task automatic check_all();
        logic [NC-1:0] eb;
        for (int i = 0; i < NC; i++) eb[i] = (run[i] >= TH);
        chk("block", axis_block_sigs, eb);
        chk("any_block", any_block, |eb);
        chk("report_valid", report_valid, m_pend);
        if (m_pend) begin
            chk("report_idx", report_idx, m_idx);
            chk("report_ts", report_ts, m_rts);
        end
        chk("report_overflow", report_overflow, m_ovf);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        enable       = 1'b1;
        clear        = 1'b0;
        tv           = '0;
        tr           = '0;
        report_ready = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_idx", report_idx, 0);
        chk("rst_ts", report_ts, 0);
        #1;
        reset = 1'b1;

        // 1: output-stream stall on ch1
        tv[1] = 1'b1;
        ticks(3);
        chk("t1_block_early", axis_block_sigs[1], 1'b0);
        tick();
        chk("t1_block", axis_block_sigs[1], 1'b1);
        tick();
        chk("t1_valid", report_valid, 1'b1);
        chk("t1_idx", report_idx, 1);
        chk("t1_ts", report_ts, 4);
        tr[1] = 1'b1;
        tick();
        chk("t1_block_fall", axis_block_sigs[1], 1'b0);
        report_ready = 1'b1;
        tick();
        tv[1] = 1'b0;
        tr[1] = 1'b0;

        // 2: input stream that keeps transferring never blocks
        for (int r = 0; r < 10; r++) begin
            tr[0] = 1'b1;
            tv[0] = 1'b0;
            ticks(3);
            chk("t2_block", axis_block_sigs[0], 1'b0);
            tv[0] = 1'b1;
            tick();
            chk("t2_valid", report_valid, 1'b0);
        end
        tv[0] = 1'b0;
        tr[0] = 1'b0;

        // 3: ch2 and ch3 rise together
        do_clear();
        report_ready = 1'b0;
        tr[2] = 1'b1;
        tv[3] = 1'b1;
        ticks(5);
        chk("t3_idx", report_idx, 2);
        chk("t3_ovf", report_overflow, 1'b1);
        tr[2] = 1'b0;
        tv[3] = 1'b0;
        report_ready = 1'b1;
        tick();

        // 4: held report, later rise only sets overflow
        do_clear();
        report_ready = 1'b0;
        tr[0] = 1'b1;
        ticks(5);
        chk("t4_idx0", report_idx, 0);
        tv[1] = 1'b1;
        ticks(5);
        chk("t4_idx_held", report_idx, 0);
        chk("t4_ovf", report_overflow, 1'b1);
        report_ready = 1'b1;
        tick();
        chk("t4_valid_drop", report_valid, 1'b0);
        tr[0] = 1'b0;
        tv[1] = 1'b0;
        do_clear();
        chk("t4_ovf_clr", report_overflow, 1'b0);
        report_ready = 1'b0;
        tv[3] = 1'b1;
        ticks(5);
        chk("t4_ts_restart", report_ts, 4);
        tv[3] = 1'b0;
        report_ready = 1'b1;
        tick();

        // 5: accept and new rise in the same cycle
        do_clear();
        report_ready = 1'b0;
        tr[0] = 1'b1;
        ticks(5);
        tr[2] = 1'b1;
        ticks(4);
        report_ready = 1'b1;
        tick();
        chk("t5_valid", report_valid, 1'b1);
        chk("t5_idx", report_idx, 2);
        chk("t5_ovf", report_overflow, 1'b0);
        tick();
        tr[0] = 1'b0;
        tr[2] = 1'b0;
        tick();

        // 6: asynchronous reset mid-stall, then enable drop during a block
        do_clear();
        tv[1] = 1'b1;
        ticks(3);
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_rst_idx", report_idx, 0);
        chk("t6_rst_ts", report_ts, 0);
        #2;
        reset = 1'b1;
        ticks(3);
        chk("t6_block_early", axis_block_sigs[1], 1'b0);
        tick();
        chk("t6_block", axis_block_sigs[1], 1'b1);
        enable = 1'b0;
        tick();
        chk("t6_block_en", axis_block_sigs[1], 1'b0);
        enable = 1'b1;
        tv[1] = 1'b0;

        // randomized traffic with persistent per-channel handshake patterns
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NC; i++) begin
                if ($urandom_range(7) == 0) begin
                    tv[i] = ($urandom_range(1) == 1);
                    tr[i] = ($urandom_range(1) == 1);
                end
            end
            report_ready = ($urandom_range(3) == 0);
            clear        = ($urandom_range(63) == 0);
            enable       = ($urandom_range(31) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
